// File: rtl/sdram_wfifo_ctrl_pkg.sv
// Shared definitions for the SDRAM write-FIFO controller: parameter defaults and
// the one-hot write-burst FSM encoding.
package sdram_wfifo_ctrl_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_BURST_LEN = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_TRIG  = 3'b010,
    ST_DRAIN = 3'b100
  } wr_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO with registered read data; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   pop,
  output logic                   push_ok,
  output logic                   pop_ok,
  output logic [DATA_W-1:0]      rd_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // When full, wr_ptr == rd_ptr; the old head is read before being overwritten.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      rd_data <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/sdram_wfifo_ctrl.sv
// Byte write FIFO for an SDRAM write engine with burst/read trigger arbitration.
// Triggers decode from registered state; a pending read yields to a ready write burst.
module sdram_wfifo_ctrl
  import sdram_wfifo_ctrl_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      rx_data,
  input  logic                   rx_valid,
  input  logic                   rd_req_in,
  input  logic                   wfifo_rd_en,
  output logic [DATA_W-1:0]      wfifo_rd_data,
  output logic                   wr_trig,
  output logic                   rd_trig,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int LW = $clog2(DEPTH) + 1;

  wr_state_t     state;
  wr_state_t     state_nxt;
  logic [LW-1:0] pop_cnt;
  logic          pend;
  logic          push_ok;
  logic          pop_ok;
  logic          burst_ready;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rx_valid),
    .push_data (rx_data),
    .pop       (wfifo_rd_en),
    .push_ok   (push_ok),
    .pop_ok    (pop_ok),
    .rd_data   (wfifo_rd_data),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  assign burst_ready = (level >= LW'(BURST_LEN));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Write has priority: the read branch is only reachable when no burst is ready.
  always_comb begin
    state_nxt = state;
    wr_trig   = 1'b0;
    rd_trig   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (burst_ready)  state_nxt = ST_TRIG;
        else if (pend)    rd_trig   = 1'b1;
      end
      ST_TRIG: begin
        wr_trig   = 1'b1;
        state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop_cnt == LW'(BURST_LEN)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pop_cnt   <= '0;
      pend      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (state == ST_TRIG)
        pop_cnt <= '0;
      else if (state == ST_DRAIN && pop_ok && pop_cnt != LW'(BURST_LEN))
        pop_cnt <= pop_cnt + LW'(1);
      pend <= rd_req_in | (pend & ~rd_trig);
      if (rx_valid && !push_ok)   overflow  <= 1'b1;
      if (wfifo_rd_en && !pop_ok) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_wfifo_ctrl.sv
// Bench for sdram_wfifo_ctrl: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sdram_wfifo_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int BL    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rd_req_in = 1'b0;
  logic          wfifo_rd_en = 1'b0;
  logic [DW-1:0] wfifo_rd_data;
  logic          wr_trig, rd_trig, full, empty, overflow, underflow;
  logic [4:0]    level;

  always #5 clk = ~clk;

  sdram_wfifo_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .BURST_LEN(BL)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rd_req_in     (rd_req_in),
    .wfifo_rd_en   (wfifo_rd_en),
    .wfifo_rd_data (wfifo_rd_data),
    .wr_trig       (wr_trig),
    .rd_trig       (rd_trig),
    .level         (level),
    .full          (full),
    .empty         (empty),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: byte queue plus a burst phase (trigger pulse / draining).
  logic [7:0] q[$];
  logic [7:0] m_rd = '0;
  bit         m_live = 0, m_trig = 0, m_draining = 0, m_pend = 0, m_ovf = 0, m_udf = 0;
  int         m_drained = 0;

  function automatic bit m_rd_fire();
    return !m_trig && !m_draining && m_pend && (q.size() < BL);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_rd = '0; m_trig = 0; m_draining = 0; m_drained = 0;
      m_pend = 0; m_ovf = 0; m_udf = 0; m_live = 1;
    end else if (m_live) begin
      automatic int sz   = q.size();
      automatic bit popa  = wfifo_rd_en && (sz > 0);
      automatic bit pusha = rx_valid && ((sz < DEPTH) || popa);
      automatic bit fire  = m_rd_fire();
      if (m_trig) begin
        m_trig = 0; m_draining = 1; m_drained = 0;
      end else if (m_draining) begin
        if (m_drained == BL) m_draining = 0;
        else if (popa) m_drained++;
      end else if (sz >= BL) begin
        m_trig = 1;
      end
      if (popa) m_rd = q.pop_front();
      if (pusha) q.push_back(rx_data);
      if (rx_valid && !pusha) m_ovf = 1;
      if (wfifo_rd_en && !popa) m_udf = 1;
      m_pend = rd_req_in || (m_pend && !fire);
    end
  end

  int cyc = 0, wr_cnt = 0, rd_cnt = 0, wr_cyc = 0, rd_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (m_live) begin
      check("level",     level,         q.size());
      check("full",      full,          q.size() == DEPTH);
      check("empty",     empty,         q.size() == 0);
      check("rd_data",   wfifo_rd_data, m_rd);
      check("wr_trig",   wr_trig,       m_trig);
      check("rd_trig",   rd_trig,       m_rd_fire());
      check("overflow",  overflow,      m_ovf);
      check("underflow", underflow,     m_udf);
      check("trig_overlap", wr_trig & rd_trig, 0);
      if (wr_trig === 1'b1) begin wr_cnt++; wr_cyc = cyc; end
      if (rd_trig === 1'b1) begin rd_cnt++; rd_cyc = cyc; end
    end
  end

  task automatic tick(input bit rn, input bit v, input logic [7:0] d, input bit re, input bit rq);
    rst_n = rn; rx_valid = v; rx_data = d; wfifo_rd_en = re; rd_req_in = rq;
    @(negedge clk);
    #1;
  endtask

  task automatic do_rst();             tick(0, 0, 8'h00, 0, 0); endtask
  task automatic idle();               tick(1, 0, 8'h00, 0, 0); endtask
  task automatic push(input logic [7:0] d); tick(1, 1, d, 0, 0); endtask
  task automatic pop();                tick(1, 0, 8'h00, 1, 0); endtask

  logic [7:0] exp_bytes [16];
  int w0, r0;

  initial begin
    do_rst(); do_rst();
    check("rst_level", level, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_rd_data", wfifo_rd_data, 0);

    // Basic burst: 4 pushes, trigger, drain in order.
    for (int i = 0; i < 4; i++) push(8'h11 + 8'(i));
    check("b_level4", level, 4);
    idle();
    check("b_wr_trig", wr_trig, 1);
    idle();
    for (int i = 0; i < 4; i++) begin
      pop();
      check("b_pop_data", wfifo_rd_data, 8'h11 + 8'(i));
    end
    idle(); idle();
    check("b_level0", level, 0);
    check("b_wr_cnt", wr_cnt, 1);
    check("model_draining", m_draining, 0);

    // Fill to full, push+pop at full, overflow, drain order, underflow.
    do_rst();
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
    check("f_full", full, 1);
    check("f_level16", level, 16);
    check("model_q16", q.size(), 16);
    tick(1, 1, 8'hAA, 1, 0);
    check("f_pp_level", level, 16);
    check("f_pp_ovf", overflow, 0);
    check("f_pp_data", wfifo_rd_data, 8'h20);
    push(8'hBB);
    check("f_ovf", overflow, 1);
    check("f_ovf_level", level, 16);
    for (int i = 0; i < 15; i++) exp_bytes[i] = 8'h21 + 8'(i);
    exp_bytes[15] = 8'hAA;
    for (int i = 0; i < 16; i++) begin
      pop();
      check("f_order", wfifo_rd_data, exp_bytes[i]);
    end
    check("f_empty", empty, 1);
    pop();
    check("u_udf", underflow, 1);
    check("u_level", level, 0);
    check("u_data", wfifo_rd_data, 8'hAA);

    // Read request coincident with a ready write burst.
    do_rst();
    for (int i = 0; i < 4; i++) push(8'h40 + 8'(i));
    tick(1, 0, 8'h00, 0, 1);
    check("a_wr_first", wr_trig, 1);
    check("a_rd_held", rd_trig, 0);
    idle();
    for (int i = 0; i < 4; i++) begin
      pop();
      check("a_rd_wait", rd_trig, 0);
    end
    idle();
    check("a_rd_trig", rd_trig, 1);
    check("a_rd_gap", rd_cyc - wr_cyc, 6);
    idle();
    check("a_rd_once", rd_trig, 0);

    // Reset in the middle of a drain.
    do_rst();
    for (int i = 0; i < 4; i++) push(8'h60 + 8'(i));
    idle(); idle(); pop();
    tick(0, 1, 8'h55, 1, 1);
    check("r_level", level, 0);
    check("r_empty", empty, 1);
    check("r_wr", wr_trig, 0);
    check("r_rd", rd_trig, 0);
    check("r_data", wfifo_rd_data, 0);
    w0 = wr_cnt; r0 = rd_cnt;
    for (int i = 0; i < 3; i++) push(8'h70 + 8'(i));
    idle(); idle(); idle();
    check("r_no_wr", wr_cnt, w0);
    check("r_no_rd", rd_cnt, r0);
    push(8'h73);
    idle();
    check("r_new_wr", wr_trig, 1);
    check("r_wr_cnt", wr_cnt, w0 + 1);

    // Randomized traffic with varying push/pop bias and rare resets.
    for (int blk = 0; blk < 6; blk++) begin
      automatic int pp = $urandom_range(15, 85);
      automatic int pq = $urandom_range(15, 85);
      for (int c = 0; c < 500; c++) begin
        tick($urandom_range(0, 299) != 0,
             $urandom_range(0, 99) < pp,
             8'($urandom),
             $urandom_range(0, 99) < pq,
             $urandom_range(0, 9) == 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
